// File: rtl/asic_iopoc_seq.sv
// IO-ring supply-bank power-on/power-off sequencer driving the ring-wide poc net.
// Optional: define ASIC_IOPOC_BROWNOUT_EN to fault on any supply-good drop while ON.
module asic_iopoc_seq #(
  parameter int NBANKS  = 4,
  parameter int CNTW    = 8,
  parameter int TIMEOUT = 16,
  parameter int SETTLE  = 8,
  parameter int OFF_GAP = 2,
  localparam int IW     = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_on,
  input  logic              i_req_off,
  input  logic [NBANKS-1:0] i_vddio_good,
  output logic [NBANKS-1:0] o_bank_en,
  output logic              o_poc,
  output logic              o_ready,
  output logic              o_fault,
  output logic [IW-1:0]     o_fault_bank,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RAMP   = 3'd1,
    S_SETTLE = 3'd2,
    S_ON     = 3'd3,
    S_DOWN   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNTW-1:0]   r_cnt, w_cnt_nxt;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic [NBANKS-1:0] r_bank_en, w_bank_en_nxt;
  logic              r_poc, w_poc_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_fault, w_fault_nxt;
  logic [IW-1:0]     r_fault_bank, w_fault_bank_nxt;
  logic [NBANKS-1:0] r_sync1, r_good_s;

  logic [NBANKS-1:0] w_drop;
  logic [IW-1:0]     w_lo;
  logic [IW-1:0]     w_hi;

  // A bank counts as dropped only while its switch is enabled.
  assign w_drop = r_bank_en & ~r_good_s;

  always_comb begin
    w_lo = '0;
    for (int i = NBANKS - 1; i >= 0; i--) begin
      if (w_drop[i]) w_lo = IW'(i);
    end
  end

  always_comb begin
    w_hi = '0;
    for (int i = 0; i < NBANKS; i++) begin
      if (r_bank_en[i]) w_hi = IW'(i);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_idx_nxt        = r_idx;
    w_bank_en_nxt    = r_bank_en;
    w_poc_nxt        = r_poc;
    w_ready_nxt      = r_ready;
    w_fault_nxt      = r_fault;
    w_fault_bank_nxt = r_fault_bank;
    case (r_state)
      S_IDLE: begin
        if (i_req_on && !i_req_off) begin
          w_state_nxt   = S_RAMP;
          w_cnt_nxt     = '0;
          w_idx_nxt     = '0;
          w_bank_en_nxt = NBANKS'(1);
        end
      end
      S_RAMP: begin
        if (i_req_off) begin
          w_state_nxt = S_DOWN;
          w_cnt_nxt   = '0;
        end else if (r_good_s[r_idx]) begin
          w_cnt_nxt = '0;
          if (int'(r_idx) < NBANKS - 1) begin
            w_idx_nxt = r_idx + 1'b1;
            for (int i = 1; i < NBANKS; i++) begin
              if (i == int'(r_idx) + 1) w_bank_en_nxt[i] = 1'b1;
            end
          end else begin
            w_state_nxt = S_SETTLE;
          end
        end else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
          w_state_nxt      = S_FAULT;
          w_cnt_nxt        = '0;
          w_bank_en_nxt    = '0;
          w_poc_nxt        = 1'b1;
          w_ready_nxt      = 1'b0;
          w_fault_nxt      = 1'b1;
          w_fault_bank_nxt = r_idx;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_SETTLE: begin
        if (i_req_off) begin
          w_state_nxt = S_DOWN;
          w_cnt_nxt   = '0;
        end else if (|w_drop) begin
          w_state_nxt      = S_FAULT;
          w_cnt_nxt        = '0;
          w_bank_en_nxt    = '0;
          w_poc_nxt        = 1'b1;
          w_ready_nxt      = 1'b0;
          w_fault_nxt      = 1'b1;
          w_fault_bank_nxt = w_lo;
        end else if (r_cnt == CNTW'(SETTLE - 1)) begin
          w_state_nxt = S_ON;
          w_cnt_nxt   = '0;
          w_poc_nxt   = 1'b0;
          w_ready_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_ON: begin
        if (i_req_off) begin
          w_state_nxt = S_DOWN;
          w_cnt_nxt   = '0;
          w_poc_nxt   = 1'b1;
          w_ready_nxt = 1'b0;
        end
`ifdef ASIC_IOPOC_BROWNOUT_EN
        else if (|w_drop) begin
          w_state_nxt      = S_FAULT;
          w_cnt_nxt        = '0;
          w_bank_en_nxt    = '0;
          w_poc_nxt        = 1'b1;
          w_ready_nxt      = 1'b0;
          w_fault_nxt      = 1'b1;
          w_fault_bank_nxt = w_lo;
        end
`else
        else begin
          w_state_nxt = S_ON;
        end
`endif
      end
      S_DOWN: begin
        // Switches shed highest bank first; IDLE one cycle after the last one opens.
        if (r_bank_en == '0) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else if (r_cnt == CNTW'(OFF_GAP - 1)) begin
          w_bank_en_nxt[w_hi] = 1'b0;
          w_cnt_nxt           = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_FAULT: begin
        if (i_req_off) begin
          w_state_nxt      = S_IDLE;
          w_cnt_nxt        = '0;
          w_idx_nxt        = '0;
          w_fault_nxt      = 1'b0;
          w_fault_bank_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_cnt_nxt     = '0;
        w_idx_nxt     = '0;
        w_bank_en_nxt = '0;
        w_poc_nxt     = 1'b1;
        w_ready_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_bank_en    <= '0;
      r_poc        <= 1'b1;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_bank <= '0;
      r_sync1      <= '0;
      r_good_s     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_bank_en    <= w_bank_en_nxt;
      r_poc        <= w_poc_nxt;
      r_ready      <= w_ready_nxt;
      r_fault      <= w_fault_nxt;
      r_fault_bank <= w_fault_bank_nxt;
      r_sync1      <= i_vddio_good;
      r_good_s     <= r_sync1;
    end
  end

  assign o_bank_en    = r_bank_en;
  assign o_poc        = r_poc;
  assign o_ready      = r_ready;
  assign o_fault      = r_fault;
  assign o_fault_bank = r_fault_bank;
  assign o_state      = r_state;

endmodule

// File: tb/tb_asic_iopoc_seq.sv
// Bench for asic_iopoc_seq: reactive supply model, event-level reference model,
// expected output changes queued with their cycle and checked by a monitor.
module tb_asic_iopoc_seq;

  localparam int NB      = 4;
  localparam int TIMEOUT = 16;
  localparam int SETTLE  = 8;
  localparam int OFF_GAP = 2;
  localparam int FBW     = 2;
  localparam int SW      = NB + 3 + FBW;
  localparam int EW      = 32 + SW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_on = 1'b0;
  logic          req_off = 1'b0;
  logic [NB-1:0] vddio = '0;
  logic [NB-1:0] bank_en;
  logic          poc, ready, fault;
  logic [FBW-1:0] fault_bank;
  logic [2:0]    state;

  asic_iopoc_seq #(.NBANKS(NB), .CNTW(8), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE), .OFF_GAP(OFF_GAP)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_on(req_on), .i_req_off(req_off),
    .i_vddio_good(vddio), .o_bank_en(bank_en), .o_poc(poc), .o_ready(ready),
    .o_fault(fault), .o_fault_bank(fault_bank), .o_state(state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- supply plant ----------------
  // Good rises dly[i] cycles after the bank switch closes (never if dly<0),
  // and falls as soon as the switch opens or drop[i] is forced.
  int            dly[NB];
  int            rise_c[NB];
  logic [NB-1:0] prev_en = '0;
  logic [NB-1:0] drop = '0;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NB; i++) begin
      if (bank_en[i] === 1'b1 && prev_en[i] !== 1'b1) rise_c[i] = cyc;
      vddio[i] = (bank_en[i] === 1'b1) && !drop[i] && (dly[i] >= 0) && (cyc >= rise_c[i] + dly[i]);
    end
    prev_en = bank_en;
  end

  // ---------------- scoreboard ----------------
  logic [SW-1:0] w_snap;
  assign w_snap = {bank_en, poc, ready, fault, fault_bank};

  function automatic logic [SW-1:0] mk(logic [NB-1:0] b, logic p, logic r, logic f, logic [FBW-1:0] fb);
    return {b, p, r, f, fb};
  endfunction

  logic [SW-1:0] idle_s;
  assign idle_s = mk('0, 1'b1, 1'b0, 1'b0, '0);

  logic [EW-1:0] exp_q[$];
  task automatic push_exp(int c, logic [SW-1:0] v);
    exp_q.push_back({32'(c), v});
  endtask

  int            n_chk = 0, n_err = 0;
  int            req_cnt = 0, done_cnt = 0;
  logic [SW-1:0] req_val;
  string         req_name;
  bit            mon_en = 0, mon_act = 0, fin_req = 0, fin_done = 0;
  logic [SW-1:0] prev_snap;
  logic [EW-1:0] mon_e;

  always @(negedge clk) begin
    if (req_cnt != done_cnt) begin
      n_chk++;
      if (w_snap !== req_val) begin
        n_err++;
        $display("FAIL %s: cycle %0d got %b want %b", req_name, cyc, w_snap, req_val);
      end
      done_cnt = req_cnt;
    end
    if (mon_en) begin
      if (!mon_act) begin
        mon_act   = 1;
        prev_snap = w_snap;
      end else if (w_snap !== prev_snap) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change: cycle %0d got %b nothing expected", cyc, w_snap);
        end else begin
          mon_e = exp_q.pop_front();
          if (int'(mon_e[EW-1:SW]) != cyc || mon_e[SW-1:0] !== w_snap) begin
            n_err++;
            $display("FAIL output_change: cycle %0d got %b want %b at cycle %0d",
                     cyc, w_snap, mon_e[SW-1:0], int'(mon_e[EW-1:SW]));
          end
        end
        prev_snap = w_snap;
      end
      while (exp_q.size() > 0 && int'(exp_q[0][EW-1:SW]) < cyc) begin
        n_chk++;
        n_err++;
        mon_e = exp_q.pop_front();
        $display("FAIL missed_change: cycle %0d want %b at cycle %0d got %b",
                 cyc, mon_e[SW-1:0], int'(mon_e[EW-1:SW]), w_snap);
      end
    end
    if (fin_req && !fin_done) begin
      n_chk++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL pending_at_end: got %0d entries want 0", exp_q.size());
      end
      fin_done = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req_chk(logic [SW-1:0] v, string nm);
    req_val  = v;
    req_name = nm;
    req_cnt++;
    @(negedge clk);
    #1;
  endtask

  // Drives the given controls so that they are sampled on edge a.
  task automatic pulse_at(int a, bit on, bit off, bit r);
    wait_until(a - 1);
    req_on  = on;
    req_off = off;
    rst     = r;
    @(posedge clk);
    #1;
    req_on  = 1'b0;
    req_off = 1'b0;
    rst     = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int            ev_c[NB+1];
  logic [SW-1:0] ev_v[NB+1];
  logic [NB-1:0] ev_b[NB+1];
  int            ev_n;
  bit            ev_on;

  task automatic add_ev(int c, logic [NB-1:0] b, logic [SW-1:0] v);
    ev_c[ev_n] = c;
    ev_b[ev_n] = b;
    ev_v[ev_n] = v;
    ev_n++;
  endtask

  // Each bank's good is seen 2 sync cycles + 1 decision cycle after it rises.
  task automatic model_ramp(int t0);
    int t;
    logic [NB-1:0] b;
    ev_n  = 0;
    ev_on = 0;
    t     = t0;
    b     = NB'(1);
    add_ev(t, b, mk(b, 1, 0, 0, '0));
    for (int i = 0; i < NB; i++) begin
      if (dly[i] < 0 || dly[i] + 3 > TIMEOUT) begin
        add_ev(t + TIMEOUT, '0, mk('0, 1, 0, 1, FBW'(i)));
        return;
      end
      t = t + dly[i] + 3;
      if (i < NB - 1) begin
        b[i+1] = 1'b1;
        add_ev(t, b, mk(b, 1, 0, 0, '0));
      end else begin
        add_ev(t + SETTLE, b, mk(b, 0, 1, 0, '0));
        ev_on = 1;
      end
    end
  endtask

  task automatic push_down(int d, logic [NB-1:0] b, output int te);
    for (int i = NB - 1; i >= 0; i--) begin
      if (b[i]) begin
        d    = d + OFF_GAP;
        b[i] = 1'b0;
        push_exp(d, mk(b, 1, 0, 0, '0));
      end
    end
    te = d;
  endtask

  // kind: 0 full run, 1 forced fault, 2 req_off abort, 3 reset abort, 4 brownout, 5 on+off together
  task automatic run_scn(int kind, bit fixed);
    int t0, te, a, k;
    logic [NB-1:0] b;
    if (kind == 5) begin
      pulse_at(cyc + 2, 1, 1, 0);
      wait_until(cyc + 4);
      req_chk(idle_s, "on_off_same_cycle");
      return;
    end
    for (int i = 0; i < NB; i++) dly[i] = fixed ? 3 : int'($urandom_range(0, 13));
    if (!fixed && $urandom_range(0, 2) == 0) dly[$urandom_range(0, NB - 1)] = 13;
    if (kind == 1) dly[fixed ? 2 : int'($urandom_range(0, NB - 1))] = ($urandom_range(0, 1) == 0 || fixed) ? -1 : 14;
    if ((kind == 2 || kind == 3) && $urandom_range(0, 3) == 0) dly[$urandom_range(0, NB - 1)] = 14;
    t0 = cyc + 2;
    model_ramp(t0);
    if (kind == 2 || kind == 3) begin
      a = t0 + 1 + int'($urandom_range(0, ev_c[ev_n-1] - t0 - 2));
      b = '0;
      for (int i = 0; i < ev_n; i++) begin
        if (ev_c[i] < a) begin
          push_exp(ev_c[i], ev_v[i]);
          b = ev_b[i];
        end
      end
      if (kind == 2) push_down(a, b, te);
      else begin
        push_exp(a, idle_s);
        te = a;
      end
      pulse_at(t0, 1, 0, 0);
      pulse_at(a, 0, kind == 2, kind == 3);
    end else begin
      for (int i = 0; i < ev_n; i++) push_exp(ev_c[i], ev_v[i]);
      pulse_at(t0, 1, 0, 0);
      wait_until(ev_c[ev_n-1] + 2);
      if (kind == 4 && ev_on) begin
        @(negedge clk);
        drop[1] = 1'b1;
        k = cyc + 1;
`ifdef ASIC_IOPOC_BROWNOUT_EN
        push_exp(k + 3, mk('0, 1, 0, 1, FBW'(1)));
        ev_on = 0;
`endif
        wait_until(k + 6);
      end
      a = cyc + 2;
      if (ev_on) begin
        push_exp(a, mk({NB{1'b1}}, 1, 0, 0, '0));
        push_down(a, {NB{1'b1}}, te);
      end else begin
        push_exp(a, idle_s);
        te = a;
      end
      pulse_at(a, 0, 1, 0);
    end
    wait_until(te + 4);
    drop = '0;
    req_chk(idle_s, "idle_after_scenario");
  endtask

  // ---------------- main ----------------
  initial begin
    for (int i = 0; i < NB; i++) begin
      dly[i]    = 0;
      rise_c[i] = 0;
    end
    @(posedge clk);
    #1;
    req_chk(idle_s, "reset_values");
    req_on = 1'b1;
    @(posedge clk);
    #1;
    req_chk(idle_s, "held_in_reset");
    req_on = 1'b0;
    rst    = 1'b0;
    mon_en = 1;
    wait_until(cyc + 3);
    run_scn(0, 1);
    run_scn(1, 1);
    run_scn(5, 0);
    run_scn(2, 0);
    run_scn(3, 0);
    run_scn(4, 0);
    for (int n = 0; n < 16; n++) run_scn(int'($urandom_range(0, 5)), 0);
    wait_until(cyc + 4);
    fin_req = 1;
    for (int n = 0; n < 5 && !fin_done; n++) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
